// File: rtl/i2c_apb_cfg_sequencer.sv
// i2c_apb_cfg_sequencer: APB master that writes prescale, slave address, TX bytes and command to the I2C controller, then polls status until done or timeout
module i2c_apb_cfg_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES = 16,
  parameter int POLL_LIMIT = 1024,
  parameter int DONE_BIT = 0,
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  start_i,
  input  logic [7:0]            prescale_i,
  input  logic [7:0]            slave_addr_i,
  input  logic [7:0]            cmd_i,
  input  logic [CW-1:0]         byte_cnt_i,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GETBYTE, NEXT, DONE, TOUT} state_t;
  typedef enum logic [2:0] {ST_PRE, ST_ADDR, ST_DATA, ST_CMD, ST_POLL} step_t;
  state_t state, nxt;
  step_t step;
  logic [7:0] addr_q, cmd_q;
  logic [CW-1:0] cnt_q, left_q;
  logic [PW-1:0] poll_cnt;
  logic not_done, unused_prdata;
  assign not_done = !prdata_i[DONE_BIT];
  assign unused_prdata = ^prdata_i;
  assign psel_o = state == SETUP || state == ACCESS;
  assign penable_o = state == ACCESS;
  assign tx_ready_o = state == GETBYTE;
  assign busy_o = state != IDLE && state != DONE && state != TOUT;
  assign done_o = state == DONE;
  assign timeout_o = state == TOUT;
  always_ff @(posedge pclk_i) state <= preset_i ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_i ? SETUP : IDLE;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = !pready_i ? ACCESS : step != ST_POLL ? NEXT : !not_done ? DONE :
                     poll_cnt == PW'(POLL_LIMIT - 1) ? TOUT : NEXT;
      GETBYTE: nxt = tx_valid_i ? SETUP : GETBYTE;
      NEXT:    nxt = (step == ST_ADDR && cnt_q != '0) || (step == ST_DATA && left_q != '0) ? GETBYTE : SETUP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      step <= ST_PRE;
      addr_q <= '0;
      cmd_q <= '0;
      cnt_q <= '0;
      left_q <= '0;
      poll_cnt <= '0;
      paddr_o <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          step <= ST_PRE;
          addr_q <= slave_addr_i;
          cmd_q <= cmd_i;
          cnt_q <= byte_cnt_i > CW'(MAX_BYTES) ? CW'(MAX_BYTES) : byte_cnt_i;
          poll_cnt <= '0;
          paddr_o <= ADDR_WIDTH'(8'h05);
          pwdata_o <= DATA_WIDTH'(prescale_i);
          pwrite_o <= 1'b1;
        end
        ACCESS: if (pready_i && step == ST_POLL && not_done) poll_cnt <= poll_cnt + 1'b1;
        GETBYTE: if (tx_valid_i) begin
          pwdata_o <= DATA_WIDTH'(tx_data_i);
          left_q <= left_q - 1'b1;
        end
        NEXT: case (step)
          ST_PRE: begin
            step <= ST_ADDR;
            paddr_o <= ADDR_WIDTH'(8'h03);
            pwdata_o <= DATA_WIDTH'(addr_q);
          end
          ST_ADDR, ST_DATA: begin
            if (step == ST_ADDR && cnt_q != '0) begin
              step <= ST_DATA;
              paddr_o <= '0;
              left_q <= cnt_q;
            end else if (step == ST_ADDR || left_q == '0) begin
              step <= ST_CMD;
              paddr_o <= ADDR_WIDTH'(8'h04);
              pwdata_o <= DATA_WIDTH'(cmd_q);
            end
          end
          ST_CMD: begin
            step <= ST_POLL;
            paddr_o <= ADDR_WIDTH'(8'h02);
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
          end
          default: ;
        endcase
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_apb_cfg_sequencer.sv
// tb_i2c_apb_cfg_sequencer: scoreboard bench with an APB slave model and TX byte source
module tb_i2c_apb_cfg_sequencer;
  localparam int PLIM = 4;
  logic pclk_i = 1'b0, preset_i, start_i, tx_valid_i, pready_i;
  logic [7:0] prescale_i, slave_addr_i, cmd_i, tx_data_i, prdata_i, paddr_o, pwdata_o;
  logic [4:0] byte_cnt_i;
  logic tx_ready_o, psel_o, penable_o, pwrite_o, busy_o, done_o, timeout_o;
  i2c_apb_cfg_sequencer #(.POLL_LIMIT(PLIM)) dut (
    .pclk_i(pclk_i), .preset_i(preset_i), .start_i(start_i), .prescale_i(prescale_i),
    .slave_addr_i(slave_addr_i), .cmd_i(cmd_i), .byte_cnt_i(byte_cnt_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );
  always #5 pclk_i = ~pclk_i;
  typedef struct packed {logic [7:0] a; logic w; logic [7:0] d;} xfer_t;
  xfer_t expq[$];
  logic [7:0] txd[$], jb[$];
  int txdl[$];
  int checks = 0, failures = 0;
  int wait_cfg = 0, wcnt = 0, sel_cyc = 0, reads = 0, polls_to_done = 0, tx_ready_cyc = 0;
  int stall_idx = -1, stall_len = 0;
  logic prev_psel = 1'b0, prev_hs = 1'b0;
  logic [16:0] snap;
  xfer_t got, exp_x;
  always @(negedge pclk_i) begin
    pready_i = 1'b0;
    if (psel_o && !penable_o) begin
      checks++;
      if (prev_psel) begin failures++; $display("FAIL apb_idle_gap: psel=1 in cycle before SETUP, required 0"); end
      snap = {paddr_o, pwdata_o, pwrite_o};
      sel_cyc = 1;
      wcnt = 0;
    end else if (psel_o && penable_o) begin
      sel_cyc++;
      checks++;
      if ({paddr_o, pwdata_o, pwrite_o} !== snap) begin
        failures++; $display("FAIL apb_hold: addr/data/write=%h required %h", {paddr_o, pwdata_o, pwrite_o}, snap);
      end
      if (wcnt < wait_cfg) wcnt++;
      else begin
        pready_i = 1'b1;
        prdata_i = pwrite_o ? 8'hFF : (reads >= polls_to_done ? 8'h01 : 8'hFE);
        if (!pwrite_o) reads++;
        checks++;
        if (sel_cyc !== 2 + wait_cfg) begin failures++; $display("FAIL apb_len: %0d cycles required %0d", sel_cyc, 2 + wait_cfg); end
        got = {paddr_o, pwrite_o, pwrite_o ? pwdata_o : 8'h00};
        checks++;
        if (expq.size() == 0) begin failures++; $display("FAIL apb_unexpected: transfer %h with none expected", got); end
        else begin
          exp_x = expq.pop_front();
          if (got !== exp_x) begin failures++; $display("FAIL apb_xfer: addr/w/data=%h required %h", got, exp_x); end
        end
      end
    end
    prev_psel = psel_o;
  end
  always @(negedge pclk_i) begin
    if (tx_ready_o) tx_ready_cyc++;
    if (prev_hs) begin
      checks++;
      if (tx_ready_o) begin failures++; $display("FAIL tx_ready_drop: tx_ready=1 after handshake, required 0"); end
    end
    prev_hs = 1'b0;
    tx_valid_i = 1'b0;
    if (tx_ready_o) begin
      checks++;
      if (psel_o) begin failures++; $display("FAIL getbyte_psel: psel=1 while waiting for byte, required 0"); end
      if (txd.size() == 0) begin checks++; failures++; $display("FAIL tx_underrun: tx_ready=1 with no byte expected"); end
      else if (txdl[0] > 0) txdl[0]--;
      else begin
        tx_valid_i = 1'b1;
        tx_data_i = txd.pop_front();
        void'(txdl.pop_front());
        prev_hs = 1'b1;
      end
    end
  end
  task automatic run_job(input logic [7:0] pre, addr, cmd, input int cnt, input int pnd, input bit exp_tout, input bit poke);
    int nreads;
    bit seen;
    expq.push_back({8'h05, 1'b1, pre});
    expq.push_back({8'h03, 1'b1, addr});
    foreach (jb[i]) begin
      expq.push_back({8'h00, 1'b1, jb[i]});
      txd.push_back(jb[i]);
      txdl.push_back(i == stall_idx ? stall_len : 0);
    end
    expq.push_back({8'h04, 1'b1, cmd});
    nreads = exp_tout ? PLIM : pnd + 1;
    for (int i = 0; i < nreads; i++) expq.push_back({8'h02, 1'b0, 8'h00});
    reads = 0;
    polls_to_done = pnd;
    tx_ready_cyc = 0;
    @(negedge pclk_i);
    {prescale_i, slave_addr_i, cmd_i, byte_cnt_i, start_i} = {pre, addr, cmd, 5'(cnt), 1'b1};
    @(negedge pclk_i);
    {prescale_i, slave_addr_i, cmd_i, byte_cnt_i, start_i} = {8'hEE, 8'hDD, 8'hCC, 5'd3, 1'b0};
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_after_start: busy=%b required 1", busy_o); end
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge pclk_i);
      start_i = 1'b0;
      if (done_o || timeout_o) begin
        seen = 1;
        checks++;
        if ({done_o, timeout_o, busy_o} !== {!exp_tout, exp_tout, 1'b0}) begin
          failures++; $display("FAIL job_end: done/timeout/busy=%b required %b", {done_o, timeout_o, busy_o}, {!exp_tout, exp_tout, 1'b0});
        end
        start_i = 1'b1;
        @(negedge pclk_i);
        start_i = 1'b0;
        checks++;
        if ({done_o, timeout_o, busy_o, psel_o} !== 4'b0) begin
          failures++; $display("FAIL after_end: done/timeout/busy/psel=%b required 0000", {done_o, timeout_o, busy_o, psel_o});
        end
      end else if (poke && tx_ready_o) begin
        start_i = 1'b1;
        poke = 0;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL job_budget: no done/timeout within 2000 cycles"); end
    checks++;
    if (expq.size() !== 0 || txd.size() !== 0) begin
      failures++; $display("FAIL job_left: %0d transfers %0d bytes outstanding, required 0", expq.size(), txd.size());
    end
    checks++;
    if (reads !== nreads) begin failures++; $display("FAIL status_reads: %0d required %0d", reads, nreads); end
    expq.delete(); txd.delete(); txdl.delete();
  endtask
  task automatic test_reset();
    preset_i = 1'b1;
    repeat (2) @(negedge pclk_i);
    checks++;
    if ({paddr_o, pwdata_o, psel_o, penable_o, pwrite_o, tx_ready_o, busy_o, done_o, timeout_o} !== '0) begin
      failures++; $display("FAIL reset_outputs: %h required 0", {paddr_o, pwdata_o, psel_o, penable_o, pwrite_o, tx_ready_o, busy_o, done_o, timeout_o});
    end
    preset_i = 1'b0;
  endtask
  task automatic test_basic();
    jb.delete(); jb.push_back(8'h55); jb.push_back(8'hAA);
    run_job(8'h10, 8'hA0, 8'h81, 2, 0, 0, 0);
  endtask
  task automatic test_zero_bytes();
    jb.delete();
    run_job(8'h22, 8'h4E, 8'h90, 0, 1, 0, 0);
    checks++;
    if (tx_ready_cyc !== 0) begin failures++; $display("FAIL zero_bytes_tx_ready: %0d cycles required 0", tx_ready_cyc); end
  endtask
  task automatic test_wait_states();
    wait_cfg = 3;
    jb.delete(); jb.push_back(8'h55); jb.push_back(8'hAA);
    run_job(8'h10, 8'hA0, 8'h81, 2, 0, 0, 0);
    wait_cfg = 0;
  endtask
  task automatic test_timeout();
    jb.delete(); jb.push_back(8'h3C);
    run_job(8'h07, 8'h42, 8'h11, 1, 1000, 1, 0);
  endtask
  task automatic test_stall_and_busy_start();
    stall_idx = 1; stall_len = 5;
    jb.delete(); jb.push_back(8'h01); jb.push_back(8'h02); jb.push_back(8'h03);
    run_job(8'h33, 8'hB2, 8'h85, 3, 2, 0, 1);
    checks++;
    if (tx_ready_cyc !== 8) begin failures++; $display("FAIL stall_tx_ready: %0d cycles required 8", tx_ready_cyc); end
    stall_idx = -1; stall_len = 0;
  endtask
  task automatic test_clamp();
    jb.delete();
    for (int i = 0; i < 16; i++) jb.push_back(8'(8'hC0 + i));
    run_job(8'h04, 8'h78, 8'h8F, 20, 0, 0, 0);
  endtask
  task automatic test_reset_mid_job();
    bit hit = 0;
    wait_cfg = 2;
    expq.push_back({8'h05, 1'b1, 8'h10});
    @(negedge pclk_i);
    {prescale_i, slave_addr_i, cmd_i, byte_cnt_i, start_i} = {8'h10, 8'hA0, 8'h81, 5'd0, 1'b1};
    @(negedge pclk_i);
    start_i = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge pclk_i);
      if (psel_o && penable_o && paddr_o == 8'h03) begin preset_i = 1'b1; hit = 1; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_reset_reach: slave address ACCESS not seen in 50 cycles"); end
    @(negedge pclk_i);
    checks++;
    if ({paddr_o, pwdata_o, psel_o, penable_o, pwrite_o, tx_ready_o, busy_o, done_o, timeout_o} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: %h required 0", {paddr_o, pwdata_o, psel_o, penable_o, pwrite_o, tx_ready_o, busy_o, done_o, timeout_o});
    end
    preset_i = 1'b0;
    wait_cfg = 0;
    checks++;
    if (expq.size() !== 0) begin failures++; $display("FAIL mid_reset_prefix: %0d transfers outstanding required 0", expq.size()); end
    expq.delete();
    test_basic();
  endtask
  initial begin
    {start_i, tx_valid_i, pready_i, prescale_i, slave_addr_i, cmd_i, byte_cnt_i, tx_data_i, prdata_i} = '0;
    preset_i = 1'b1;
    test_reset();
    test_basic();
    test_zero_bytes();
    test_wait_states();
    test_timeout();
    test_stall_and_busy_start();
    test_clamp();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
